// File: rtl/approx_err_pkg.sv
// Shared constants and state encoding for the approximate-unit error statistics stage.
package approx_err_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_SUM_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;
endpackage

// File: rtl/err_dist.sv
// Absolute error distance and inequality flag for one (approximate, exact) pair.
module err_dist #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] ed,
  output logic             neq
);
  assign ed  = (a >= b) ? (a - b) : (b - a);
  assign neq = (a != b);
endmodule

// File: rtl/approx_err_accum.sv
// Windowed error statistics (saturating sum, max, error count) over a valid/ready pair stream.
// state  | meaning
// IDLE   | waiting for start; last statistics held
// RUN    | accepting pairs until win_len samples seen
// REPORT | statistics presented until out_ready
module approx_err_accum
  import approx_err_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SUM_W = DEF_SUM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] approx_res,
  input  logic [WIDTH-1:0] exact_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] err_sum,
  output logic [WIDTH-1:0] err_max,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);
  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_win_len;
  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] r_sum;
  logic [WIDTH-1:0] r_max;
  logic [CNT_W-1:0] r_ecnt;

  logic [WIDTH-1:0] w_ed;
  logic             w_neq;
  logic             w_accept;
  logic             w_last;
  logic [CNT_W:0]   w_cnt_inc;
  logic [SUM_W:0]   w_sum_ext;
  logic [SUM_W-1:0] w_sum_sat;

  err_dist #(.WIDTH(WIDTH)) u_err_dist (
    .a   (approx_res),
    .b   (exact_res),
    .ed  (w_ed),
    .neq (w_neq)
  );

  assign w_accept  = (r_state == ST_RUN) && in_valid;
  // One extra bit so a window of 2^CNT_W-1 compares without wrap.
  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_last    = w_accept && (w_cnt_inc == {1'b0, r_win_len});
  assign w_sum_ext = {1'b0, r_sum} + {{(SUM_W + 1 - WIDTH){1'b0}}, w_ed};
  assign w_sum_sat = w_sum_ext[SUM_W] ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (start) w_next = (win_len == '0) ? ST_REPORT : ST_RUN;
      ST_RUN:    if (w_last) w_next = ST_REPORT;
      ST_REPORT: if (out_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_len <= '0;
      r_cnt     <= '0;
      r_sum     <= '0;
      r_max     <= '0;
      r_ecnt    <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_win_len <= win_len;
      r_cnt     <= '0;
      r_sum     <= '0;
      r_max     <= '0;
      r_ecnt    <= '0;
    end else if (w_accept) begin
      r_cnt  <= w_cnt_inc[CNT_W-1:0];
      r_sum  <= w_sum_sat;
      r_max  <= (w_ed > r_max) ? w_ed : r_max;
      r_ecnt <= r_ecnt + {{(CNT_W-1){1'b0}}, w_neq};
    end
  end

  assign in_ready  = (r_state == ST_RUN);
  assign out_valid = (r_state == ST_REPORT);
  assign busy      = (r_state == ST_RUN) || (r_state == ST_REPORT);
  assign err_sum   = r_sum;
  assign err_max   = r_max;
  assign err_cnt   = r_ecnt;
endmodule
